// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared types and helpers for the data/instruction memory responder.
//   mem_resp_t      - one response-pipeline entry {valid, rdata, err}
//   MEM_LATENCY_MAX - deepest response pipeline the responder supports
//   be_merge        - byte-lane merge of write data into an existing word
package riscv_mem_pkg;

    localparam int MEM_LATENCY_MAX = 8;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        err;
    } mem_resp_t;

    function automatic logic [31:0] be_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] m;
        m = old;
        for (int n = 0; n < 4; n++)
            if (be[n]) m[8*n +: 8] = wdata[8*n +: 8];
        return m;
    endfunction

endpackage

// File: rtl/riscv_mem_resp_pipe.sv
// riscv_mem_resp_pipe: LATENCY-stage shift register carrying responses in acceptance order.
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset, drops every in-flight entry
//   resp_i - entry pushed into stage 0 each cycle (all-zero when nothing was accepted)
//   resp_o - registered output of the last stage
module riscv_mem_resp_pipe
    import riscv_mem_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  mem_resp_t resp_i,
    output mem_resp_t resp_o
);

    mem_resp_t stage_q [LATENCY];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= resp_i;
            for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign resp_o = stage_q[LATENCY-1];

endmodule

// File: rtl/riscv_data_mem_responder.sv
// riscv_data_mem_responder: req/gnt memory responder with byte-enable RAM, fixed response
// latency, an outstanding-transaction limit and out-of-range error reporting.
//   clk_i, rst_ni                 - clock, asynchronous active-low reset
//   stall_i                       - forces gnt low
//   data_req_i / data_gnt_o       - address phase; accept = req && gnt
//   data_we_i, data_be_i          - write select, byte-lane enables
//   data_addr_i, data_wdata_i     - byte address (bits [1:0] ignored), write data
//   data_rvalid_o, data_rdata_o,
//   data_err_o                    - in-order response phase, LATENCY cycles after accept
module riscv_data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS       = 4096,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int unsigned AW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0]  MAX_CNT = 4'(MAX_OUTSTANDING);

    logic [31:0] mem_q [MEM_WORDS];
    logic [31:0] idx;
    logic        in_range;
    logic        accept;
    logic [3:0]  cnt_q, cnt_d;
    mem_resp_t   push, resp;

    // Wrapping subtract: addresses below BASE_ADDR are rejected by the explicit compare.
    assign idx      = (data_addr_i - BASE_ADDR) >> 2;
    assign in_range = (data_addr_i >= BASE_ADDR) && (idx < MEM_WORDS);

    // Decided on the registered count only; a response retiring this cycle frees no slot yet.
    assign data_gnt_o = rst_ni && data_req_i && !stall_i && (cnt_q < MAX_CNT);
    assign accept     = data_req_i && data_gnt_o;

    // Read data is sampled before the edge, so a write accepted earlier is already visible.
    assign push = '{valid: accept,
                    rdata: (accept && !data_we_i && in_range) ? mem_q[idx[AW-1:0]] : 32'h0,
                    err:   accept && !in_range};

    always_ff @(posedge clk_i) begin
        if (accept && data_we_i && in_range)
            mem_q[idx[AW-1:0]] <= be_merge(mem_q[idx[AW-1:0]], data_wdata_i, data_be_i);
    end

    riscv_mem_resp_pipe #(.LATENCY(int'(LATENCY))) u_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .resp_i (push),
        .resp_o (resp)
    );

    always_comb begin
        cnt_d = cnt_q;
        cnt_d = (accept && !resp.valid) ? cnt_q + 4'd1 :
                (!accept && resp.valid) ? cnt_q - 4'd1 : cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign data_rvalid_o = resp.valid;
    assign data_rdata_o  = resp.rdata;
    assign data_err_o    = resp.err;

    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(resp.valid && !accept && cnt_q == 4'd0));
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= MAX_CNT);

endmodule

// File: tb/tb_riscv_data_mem_responder.sv
// tb_riscv_data_mem_responder: randomized scoreboard bench for riscv_data_mem_responder.
module tb_riscv_data_mem_responder;

    localparam int LAT   = 3;
    localparam int MAXO  = 2;
    localparam int WORDS = 4096;

    logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, req = 1'b0, we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;

    int checks = 0, errors = 0, cyc = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          acc_q[$];
    logic [31:0] mdl [int];
    exp_t        mon_e;

    riscv_data_mem_responder #(
        .MEM_WORDS(WORDS), .BASE_ADDR(32'h0), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall),
        .data_req_i(req), .data_gnt_o(gnt), .data_we_i(we), .data_be_i(be),
        .data_addr_i(addr), .data_wdata_i(wdata),
        .data_rvalid_o(rvalid), .data_rdata_o(rdata), .data_err_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One bus cycle: drive at posedge+1, judge gnt at negedge, leave at the next posedge+1.
    task automatic drive(input logic r, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d, input logic s,
                         output logic acc);
        int          n;
        exp_t        e;
        logic        in_r;
        int          k;
        logic [31:0] t;
        req = r; we = w; be = b; addr = a; wdata = d; stall = s;
        @(negedge clk);
        while (acc_q.size() > 0 && acc_q[0] + LAT < cyc) void'(acc_q.pop_front());
        n = 0;
        foreach (acc_q[i]) if (acc_q[i] < cyc && cyc <= acc_q[i] + LAT) n++;
        chk("gnt", {31'b0, gnt}, {31'b0, rst_n && r && !s && n < MAXO});
        acc = r && gnt;
        if (acc) begin
            in_r  = a < WORDS * 4;
            k     = int'(a >> 2);
            e.due = cyc + LAT;
            e.err = !in_r;
            e.rdata = 32'h0;
            if (w) begin
                if (in_r) begin
                    t = mdl[k];
                    for (int l = 0; l < 4; l++) if (b[l]) t[8*l +: 8] = d[8*l +: 8];
                    mdl[k] = t;
                end
            end else if (in_r) begin
                e.rdata = mdl[k];
            end
            sb.push_back(e);
            acc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, input int stall_pct);
        logic acc;
        int   t;
        t = 0;
        do begin
            drive(1'b1, w, b, a, d, $urandom_range(99) < stall_pct, acc);
            t++;
        end while (!acc && t < 50);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout addr %h: got no gnt expected gnt within 50 cycles", a);
        end
        req = 1'b0;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, acc);
    endtask

    function automatic logic [31:0] rand_addr();
        int w;
        if ($urandom_range(9) == 0) begin
            case ($urandom_range(3))
                0: return 32'h0000_4000;
                1: return 32'h0000_4004 + $urandom_range(255);
                2: return 32'hFFFF_FFFC;
                default: return 32'h8000_0000;
            endcase
        end
        w = $urandom_range(16);
        return 32'((w == 16 ? WORDS - 1 : w) * 4 + $urandom_range(3));
    endfunction

    // Monitor: every response is popped and compared in order, including its arrival cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
            chk("rst_rdata", rdata, 32'h0);
            chk("rst_err", {31'b0, err}, 32'h0);
        end else if (rvalid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid at cycle %0d: got rvalid 1 expected 0", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("rdata", rdata, mon_e.rdata);
                chk("err", {31'b0, err}, {31'b0, mon_e.err});
                chk("rvalid_cycle", cyc, mon_e.due);
            end
        end else begin
            chk("idle_rdata", rdata, 32'h0);
            chk("idle_err", {31'b0, err}, 32'h0);
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_rvalid at cycle %0d: got rvalid 0 expected 1 (due %0d)",
                         cyc, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic acc;
        int   t;
        drive(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, acc);
        rst_n = 1'b1;
        idle(2);

        for (int w = 0; w <= 16; w++)
            xact(1'b1, 4'hF, 32'((w == 16 ? WORDS - 1 : w) * 4), $urandom, 0);
        idle(LAT + 1);

        xact(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 0);
        xact(1'b0, 4'h0, 32'h10, 32'h0, 0);
        xact(1'b1, 4'hF, 32'h20, 32'h1122_3344, 0);
        xact(1'b1, 4'h2, 32'h20, 32'h0000_AA00, 0);
        xact(1'b0, 4'h0, 32'h20, 32'h0, 0);
        xact(1'b0, 4'h0, 32'h4000, 32'h0, 0);
        xact(1'b1, 4'hF, 32'h4000, 32'h1234_5678, 0);
        xact(1'b0, 4'h0, 32'h0, 32'h0, 0);
        xact(1'b0, 4'h0, 32'h3FFC, 32'h0, 0);
        idle(LAT + 1);

        for (int i = 0; i < 6; i++) xact(1'b0, 4'h0, 32'(i * 4), 32'h0, 0);
        idle(LAT + 1);

        xact(1'b0, 4'h0, 32'h4, 32'h0, 0);
        xact(1'b0, 4'h0, 32'h8, 32'h0, 0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 4'h0, 32'hC, 32'h0, 1'b1, acc);
        xact(1'b0, 4'h0, 32'hC, 32'h0, 0);
        idle(LAT + 1);

        xact(1'b1, 4'hF, 32'h30, 32'hCAFE_F00D, 0);
        rst_n = 1'b0;
        sb.delete();
        acc_q.delete();
        idle(1);
        rst_n = 1'b1;
        xact(1'b0, 4'h0, 32'h30, 32'h0, 0);
        xact(1'b0, 4'h0, 32'h34, 32'h0, 0);
        idle(LAT + 1);

        for (int i = 0; i < 300; i++) begin
            xact($urandom_range(1) == 1, 4'($urandom_range(15)), rand_addr(), $urandom, 20);
            if ($urandom_range(3) == 0) idle($urandom_range(3));
        end

        t = 0;
        while (sb.size() > 0 && t < 20) begin
            idle(1);
            t++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending responses expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_data_mem_responder.md
Name: riscv_data_mem_responder

Overview:
- Memory-side responder for the core's data (and, via instantiation, instruction) memory interface: req/gnt address phase followed by an in-order rvalid response phase.
- Holds a word-addressed behavioural RAM with byte-enable writes.
- Returns responses after a fixed programmable latency, limits outstanding transactions, and flags out-of-range accesses with err.
- Used in the core testbench and in out-of-context (OOC) system builds as the peer of the core's data_* ports.

Parameters:
- MEM_WORDS, 4096, number of 32-bit words in the RAM array.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- LATENCY, 1, cycles from accept edge to rvalid; legal range 1..8.
- MAX_OUTSTANDING, 2, accepted-but-unanswered transactions allowed; legal range 1..LATENCY+1.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- stall_i  in  1  test hook; when 1, gnt is forced low.
- data_req_i  in  1  request valid.
- data_gnt_o  out  1  grant; a transaction is accepted when req && gnt.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  4  byte enables, bit n covers byte lane n.
- data_addr_i  in  32  byte address; bits [1:0] are ignored.
- data_wdata_i  in  32  write data.
- data_rvalid_o  out  1  response valid; one pulse per accepted transaction.
- data_rdata_o  out  32  read data; valid only with rvalid on a read.
- data_err_o  out  1  error flag; valid only with rvalid.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values:
  - All response-pipeline valid bits 0; data_rvalid_o 0, data_rdata_o 0, data_err_o 0.
  - Outstanding counter 0.
  - data_gnt_o 0 while rst_ni is low.
  - RAM contents are not reset.
- Grant (combinational): data_gnt_o = data_req_i && !stall_i && (outstanding_cnt < MAX_OUTSTANDING).
  - No registered gnt; gnt may drop in the same cycle req rises.
  - The requester must hold its request fields stable until granted.
- Address decode: idx = (data_addr_i - BASE_ADDR) >> 2, computed as a 32-bit unsigned subtract.
  - in_range = (data_addr_i >= BASE_ADDR) && (idx < MEM_WORDS).
- Accept cycle (req && gnt, rising edge):
  - Write and in_range: for each lane n with be[n] = 1, mem[idx][8n+7:8n] <= wdata[8n+7:8n]. Lanes with be[n] = 0 are unchanged.
  - Read and in_range: captured response data = mem[idx] as it stands before this edge.
  - Either direction, not in_range: no RAM update; captured rdata = 0, err = 1.
  - Write response: rdata = 0, err = !in_range.
  - Push {valid = 1, rdata, err} into stage 0 of a LATENCY-deep shift pipeline.
- Response timing:
  - data_rvalid_o, data_rdata_o and data_err_o are the registered outputs of the last pipeline stage.
  - rvalid asserts exactly LATENCY cycles after the accept edge, for one cycle.
  - When not valid, rdata and err are driven to 0.
  - Responses are strictly in acceptance order.
  - There is no response backpressure; the requester must always accept rvalid.
- Ordering: a read accepted after a write to the same word returns the written data. The write commits at its accept edge and the read samples at a later edge.
- Outstanding counter:
  - +1 on accept, -1 on rvalid; unchanged if both happen in the same cycle.
  - Never exceeds MAX_OUTSTANDING.
  - Counter underflow is an assertion failure.
- Back-to-back: with LATENCY = 1 and MAX_OUTSTANDING >= 2, one accept per cycle is sustainable.
- Counter full: when the counter is full and a response retires this cycle, gnt stays low this cycle. It is a registered-count decision, not bypassed.
- stall_i: when asserted mid-stream, in-flight responses still drain at their scheduled cycles.
- Reset mid-operation: all in-flight responses are discarded with no rvalid. RAM writes already committed persist.

Decomposition:
- Package riscv_mem_pkg:
  - typedef mem_resp_t = struct {valid, rdata[31:0], err}.
  - Constant MEM_LATENCY_MAX = 8.
  - Function be_merge(old, wdata, be) returning the merged 32-bit word.
- Sub-module riscv_mem_resp_pipe:
  - Parameterised LATENCY-stage shift register of mem_resp_t, async active-low reset of the valid bits.
- Top level contains decode, RAM array, grant logic and outstanding counter.

Test Plan:
- Full-word write then read: LATENCY = 1; write addr 0x10, be = 0xF, wdata 0xDEADBEEF; then read 0x10 -> read rvalid exactly 1 cycle after its accept, rdata 0xDEADBEEF, err 0.
- Byte enables: write 0x11223344 to 0x20, then write be = 0x2, wdata 0x0000AA00 -> read 0x20 returns 0x1122AA44.
- Out of range: MEM_WORDS = 4096; read 0x4000 -> rvalid with err 1, rdata 0. Write 0x4000 followed by a read of 0x0 -> word 0 unchanged.
- Outstanding limit and latency: LATENCY = 3, MAX_OUTSTANDING = 2, req held high for 6 cycles -> gnt high in cycles 0 and 1, low in cycles 2 and 3, high again in cycle 4 (when the counter has dropped to 1). Responses arrive in order at cycles 3, 4, 7.
- stall_i: assert stall_i for 4 cycles during a stream -> gnt = 0 throughout; both in-flight rvalids still appear on schedule.
- Mid-flight reset: pulse rst_ni low 1 cycle after an accept at LATENCY = 3 -> no rvalid, counter 0. A following read of the previously written word returns the old data.
